// File: rtl/eth_tx_frame_arbiter.sv
// ============================================================================
// Module : eth_tx_frame_arbiter
// Two-requester byte-stream frame arbiter for a 1G MAC TX input, with a
// per-frame length cap (truncate, mark bad, drop the rest) and frame stats.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module eth_tx_frame_arbiter #(
  parameter int MAX_FRAME_LENGTH = 1518,
  parameter int STRICT_PRIORITY  = 0
) (
  input  logic        tx_clk,
  input  logic        tx_rst,

  input  logic [7:0]  s0_axis_tdata,
  input  logic        s0_axis_tvalid,
  output logic        s0_axis_tready,
  input  logic        s0_axis_tlast,
  input  logic        s0_axis_tuser,

  input  logic [7:0]  s1_axis_tdata,
  input  logic        s1_axis_tvalid,
  output logic        s1_axis_tready,
  input  logic        s1_axis_tlast,
  input  logic        s1_axis_tuser,

  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,

  output logic        busy,
  output logic        stat_valid,
  output logic        stat_port,
  output logic [10:0] stat_len,
  output logic        stat_truncated
);

  localparam logic [1:0]  c_st_idle  = 2'd0;
  localparam logic [1:0]  c_st_xfer  = 2'd1;
  localparam logic [1:0]  c_st_drop  = 2'd2;
  localparam logic [10:0] c_max_len  = 11'(MAX_FRAME_LENGTH);
  localparam logic [10:0] c_last_idx = 11'(MAX_FRAME_LENGTH - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_grant;
  logic        r_rr_last;
  logic [10:0] r_cnt;

  logic [7:0]  w_g_tdata;
  logic        w_g_tvalid;
  logic        w_g_tlast;
  logic        w_g_tuser;
  logic        w_any_req;
  logic        w_pick;
  logic        w_at_max;
  logic        w_beat;

  assign w_g_tdata  = r_grant ? s1_axis_tdata  : s0_axis_tdata;
  assign w_g_tvalid = r_grant ? s1_axis_tvalid : s0_axis_tvalid;
  assign w_g_tlast  = r_grant ? s1_axis_tlast  : s0_axis_tlast;
  assign w_g_tuser  = r_grant ? s1_axis_tuser  : s0_axis_tuser;

  assign w_any_req  = s0_axis_tvalid | s1_axis_tvalid;
  assign w_at_max   = (r_cnt == c_last_idx);
  assign w_beat     = m_axis_tvalid & m_axis_tready;

  // A lone requester wins outright; a tie goes to port 0 or to the port not served last.
  always_comb begin
    w_pick = s1_axis_tvalid;
    if (s0_axis_tvalid && s1_axis_tvalid) begin
      w_pick = (STRICT_PRIORITY != 0) ? 1'b0 : ~r_rr_last;
    end
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_any_req) w_state_nxt = c_st_xfer;
      c_st_xfer: begin
        if (w_beat) begin
          if (w_g_tlast)     w_state_nxt = c_st_idle;
          else if (w_at_max) w_state_nxt = c_st_drop;
        end
      end
      c_st_drop: if (w_g_tvalid && w_g_tlast) w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    m_axis_tdata   = w_g_tdata;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    busy           = (r_state != c_st_idle);
    case (r_state)
      c_st_xfer: begin
        m_axis_tvalid  = w_g_tvalid;
        // The byte at the cap closes the frame on the wire and is flagged bad.
        m_axis_tlast   = w_g_tlast | w_at_max;
        m_axis_tuser   = w_g_tuser | (w_at_max & ~w_g_tlast);
        s0_axis_tready = ~r_grant & m_axis_tready;
        s1_axis_tready =  r_grant & m_axis_tready;
      end
      c_st_drop: begin
        s0_axis_tready = ~r_grant;
        s1_axis_tready =  r_grant;
      end
      default: ;
    endcase
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      r_grant        <= 1'b0;
      r_rr_last      <= 1'b1;
      r_cnt          <= 11'd0;
      stat_valid     <= 1'b0;
      stat_port      <= 1'b0;
      stat_len       <= 11'd0;
      stat_truncated <= 1'b0;
    end else begin
      stat_valid <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_any_req) begin
            r_grant <= w_pick;
            r_cnt   <= 11'd0;
          end
        end
        c_st_xfer: begin
          if (w_beat) begin
            r_cnt <= r_cnt + 11'd1;
            if (w_g_tlast) begin
              stat_valid     <= 1'b1;
              stat_port      <= r_grant;
              stat_len       <= r_cnt + 11'd1;
              stat_truncated <= 1'b0;
              r_rr_last      <= r_grant;
            end
          end
        end
        c_st_drop: begin
          if (w_g_tvalid && w_g_tlast) begin
            stat_valid     <= 1'b1;
            stat_port      <= r_grant;
            stat_len       <= c_max_len;
            stat_truncated <= 1'b1;
            r_rr_last      <= r_grant;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eth_tx_frame_arbiter.sv
// ============================================================================
// Module : tb_eth_tx_frame_arbiter
// Randomized self-checking bench for eth_tx_frame_arbiter (three parameter sets).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_eth_tx_frame_arbiter;

  logic        tx_clk = 1'b0;
  logic        tx_rst = 1'b1;
  logic [7:0]  s0_tdata = 8'd0, s1_tdata = 8'd0;
  logic        s0_tvalid = 1'b0, s0_tlast = 1'b0, s0_tuser = 1'b0;
  logic        s1_tvalid = 1'b0, s1_tlast = 1'b0, s1_tuser = 1'b0;
  logic        m_tready = 1'b1;

  // Per-instance outputs: 0 = RR/1518, 1 = strict/1518, 2 = RR/64
  logic        d_s0_tready [3];
  logic        d_s1_tready [3];
  logic [7:0]  d_m_tdata   [3];
  logic        d_m_tvalid  [3];
  logic        d_m_tlast   [3];
  logic        d_m_tuser   [3];
  logic        d_busy      [3];
  logic        d_stat_valid[3];
  logic        d_stat_port [3];
  logic [10:0] d_stat_len  [3];
  logic        d_stat_trunc[3];

  logic [1:0]  sel = 2'd0;
  logic        s0_tready, s1_tready, m_tvalid, m_tlast, m_tuser, busy;
  logic        stat_valid, stat_port, stat_trunc;
  logic [7:0]  m_tdata;
  logic [10:0] stat_len;

  always_comb begin
    s0_tready  = d_s0_tready[sel];
    s1_tready  = d_s1_tready[sel];
    m_tdata    = d_m_tdata[sel];
    m_tvalid   = d_m_tvalid[sel];
    m_tlast    = d_m_tlast[sel];
    m_tuser    = d_m_tuser[sel];
    busy       = d_busy[sel];
    stat_valid = d_stat_valid[sel];
    stat_port  = d_stat_port[sel];
    stat_len   = d_stat_len[sel];
    stat_trunc = d_stat_trunc[sel];
  end

  eth_tx_frame_arbiter #(.MAX_FRAME_LENGTH(1518), .STRICT_PRIORITY(0)) u_rr (
    .tx_clk(tx_clk), .tx_rst(tx_rst),
    .s0_axis_tdata(s0_tdata), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(d_s0_tready[0]),
    .s0_axis_tlast(s0_tlast), .s0_axis_tuser(s0_tuser),
    .s1_axis_tdata(s1_tdata), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(d_s1_tready[0]),
    .s1_axis_tlast(s1_tlast), .s1_axis_tuser(s1_tuser),
    .m_axis_tdata(d_m_tdata[0]), .m_axis_tvalid(d_m_tvalid[0]), .m_axis_tready(m_tready),
    .m_axis_tlast(d_m_tlast[0]), .m_axis_tuser(d_m_tuser[0]),
    .busy(d_busy[0]), .stat_valid(d_stat_valid[0]), .stat_port(d_stat_port[0]),
    .stat_len(d_stat_len[0]), .stat_truncated(d_stat_trunc[0]));

  eth_tx_frame_arbiter #(.MAX_FRAME_LENGTH(1518), .STRICT_PRIORITY(1)) u_sp (
    .tx_clk(tx_clk), .tx_rst(tx_rst),
    .s0_axis_tdata(s0_tdata), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(d_s0_tready[1]),
    .s0_axis_tlast(s0_tlast), .s0_axis_tuser(s0_tuser),
    .s1_axis_tdata(s1_tdata), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(d_s1_tready[1]),
    .s1_axis_tlast(s1_tlast), .s1_axis_tuser(s1_tuser),
    .m_axis_tdata(d_m_tdata[1]), .m_axis_tvalid(d_m_tvalid[1]), .m_axis_tready(m_tready),
    .m_axis_tlast(d_m_tlast[1]), .m_axis_tuser(d_m_tuser[1]),
    .busy(d_busy[1]), .stat_valid(d_stat_valid[1]), .stat_port(d_stat_port[1]),
    .stat_len(d_stat_len[1]), .stat_truncated(d_stat_trunc[1]));

  eth_tx_frame_arbiter #(.MAX_FRAME_LENGTH(64), .STRICT_PRIORITY(0)) u_rr64 (
    .tx_clk(tx_clk), .tx_rst(tx_rst),
    .s0_axis_tdata(s0_tdata), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(d_s0_tready[2]),
    .s0_axis_tlast(s0_tlast), .s0_axis_tuser(s0_tuser),
    .s1_axis_tdata(s1_tdata), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(d_s1_tready[2]),
    .s1_axis_tlast(s1_tlast), .s1_axis_tuser(s1_tuser),
    .m_axis_tdata(d_m_tdata[2]), .m_axis_tvalid(d_m_tvalid[2]), .m_axis_tready(m_tready),
    .m_axis_tlast(d_m_tlast[2]), .m_axis_tuser(d_m_tuser[2]),
    .busy(d_busy[2]), .stat_valid(d_stat_valid[2]), .stat_port(d_stat_port[2]),
    .stat_len(d_stat_len[2]), .stat_truncated(d_stat_trunc[2]));

  initial forever #4 tx_clk = ~tx_clk;

  int nchecks = 0;
  int nerrors = 0;
  int cyc = 0;
  bit rdy_rand = 1'b0;

  // Frame store shared by drivers and reference model
  logic [7:0] fdata [2][4][2048];
  int         flen  [2][4];
  bit         fuser [2][4];
  int         nfr   [2];

  logic [9:0]  exp_q[$];
  logic [9:0]  obeat_q[$];
  logic [12:0] exp_stat[$];
  logic [12:0] ostat_q[$];

  bit mon_en = 1'b0;
  bit seen_valid, have_last;
  int valid_rise_cyc, first_beat_cyc, last_tlast_cyc, gap_viol;

  initial forever begin
    @(posedge tx_clk);
    cyc++;
  end

  initial forever begin
    @(posedge tx_clk);
    #1;
    m_tready = rdy_rand ? ($urandom_range(0, 99) < 70) : 1'b1;
  end

  initial forever begin
    @(negedge tx_clk);
    if (mon_en) begin
      if (!seen_valid && (s0_tvalid || s1_tvalid)) begin
        seen_valid     = 1'b1;
        valid_rise_cyc = cyc;
      end
      if (m_tvalid && m_tready) begin
        if (obeat_q.size() == 0) first_beat_cyc = cyc;
        if (have_last && cyc == last_tlast_cyc + 1) gap_viol++;
        if (m_tlast) begin
          have_last      = 1'b1;
          last_tlast_cyc = cyc;
        end
        obeat_q.push_back({m_tuser, m_tlast, m_tdata});
      end
      if (stat_valid) ostat_q.push_back({stat_port, stat_trunc, stat_len});
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_frame(input int p, input int f, input int len);
    flen[p][f]  = len;
    fuser[p][f] = $urandom_range(0, 1);
    for (int b = 0; b < len; b++) fdata[p][f][b] = 8'($urandom);
  endtask

  task automatic put(input int p, input logic v, input logic [7:0] d, input logic l, input logic u);
    if (p == 0) begin
      s0_tvalid = v; s0_tdata = d; s0_tlast = l; s0_tuser = u;
    end else begin
      s1_tvalid = v; s1_tdata = d; s1_tlast = l; s1_tuser = u;
    end
  endtask

  task automatic drive_port(input int p, input int gap_pct, input int abort_at, output bit ok);
    int  sent = 0;
    int  t;
    bit  hs;
    bit  lst;
    ok = 1'b1;
    for (int f = 0; f < nfr[p]; f++) begin
      for (int b = 0; b < flen[p][f]; b++) begin
        while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
          put(p, 1'b0, 8'd0, 1'b0, 1'b0);
          @(posedge tx_clk);
          #1;
        end
        lst = (b == flen[p][f] - 1);
        put(p, 1'b1, fdata[p][f][b], lst, lst & fuser[p][f]);
        t = 0;
        do begin
          @(negedge tx_clk);
          hs = (p == 0) ? s0_tready : s1_tready;
          @(posedge tx_clk);
          #1;
          t++;
        end while (!hs && t < 2000);
        if (!hs) begin
          ok = 1'b0;
          put(p, 1'b0, 8'd0, 1'b0, 1'b0);
          return;
        end
        sent++;
        if (abort_at > 0 && sent == abort_at) return;
      end
    end
    put(p, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  // Reference: while both ports have frames pending the tie rule decides; cap applies per frame.
  task automatic build_expect(input int maxlen, input bit strict);
    int idx[2];
    int rr_last = 1;
    int p, len, n;
    bit u;
    idx[0] = 0;
    idx[1] = 0;
    exp_q.delete();
    exp_stat.delete();
    while (idx[0] < nfr[0] || idx[1] < nfr[1]) begin
      if (idx[0] < nfr[0] && idx[1] < nfr[1]) p = strict ? 0 : 1 - rr_last;
      else p = (idx[0] < nfr[0]) ? 0 : 1;
      len = flen[p][idx[p]];
      n   = (len > maxlen) ? maxlen : len;
      for (int b = 0; b < n; b++) begin
        u = (b == n - 1) ? ((len > maxlen) ? 1'b1 : fuser[p][idx[p]]) : 1'b0;
        exp_q.push_back({u, (b == n - 1) ? 1'b1 : 1'b0, fdata[p][idx[p]][b]});
      end
      exp_stat.push_back({p[0], (len > maxlen) ? 1'b1 : 1'b0, 11'(n)});
      rr_last = p;
      idx[p]++;
    end
  endtask

  function automatic int stream_mismatch();
    if (obeat_q.size() != exp_q.size())
      return (obeat_q.size() < exp_q.size()) ? obeat_q.size() : exp_q.size();
    foreach (exp_q[i]) if (obeat_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    tx_rst = 1'b1;
    put(0, 1'b0, 8'd0, 1'b0, 1'b0);
    put(1, 1'b0, 8'd0, 1'b0, 1'b0);
    repeat (3) @(posedge tx_clk);
    #1 tx_rst = 1'b0;
    @(posedge tx_clk);
    #1;
  endtask

  task automatic run_traffic(input int gap_pct, input int abort0, output bit ok);
    bit ok0, ok1;
    obeat_q.delete();
    ostat_q.delete();
    gap_viol   = 0;
    have_last  = 1'b0;
    seen_valid = 1'b0;
    mon_en     = 1'b1;
    fork
      drive_port(0, gap_pct, abort0, ok0);
      drive_port(1, gap_pct, -1, ok1);
    join
    if (abort0 <= 0) begin
      repeat (6) @(posedge tx_clk);
      #1;
    end
    ok = ok0 & ok1;
  endtask

  task automatic test_reset();
    sel = 2'd0;
    tx_rst = 1'b1;
    @(posedge tx_clk);
    #1;
    nchecks++;
    if ({m_tvalid, s0_tready, s1_tready, busy, stat_valid} !== 5'b0) begin
      nerrors++;
      $display("FAIL reset_ctrl: got %b need 00000", {m_tvalid, s0_tready, s1_tready, busy, stat_valid});
    end
    nchecks++;
    if ({stat_port, stat_trunc, stat_len} !== 13'd0) begin
      nerrors++;
      $display("FAIL reset_stat: got %h need 0", {stat_port, stat_trunc, stat_len});
    end
    do_reset();
    repeat (3) @(posedge tx_clk);
    #1;
    nchecks++;
    if ({busy, m_tvalid} !== 2'b00) begin
      nerrors++;
      $display("FAIL idle_after_reset: busy/m_tvalid got %b need 00", {busy, m_tvalid});
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    int mm;
    sel = 2'd0; rdy_rand = 1'b0;
    nfr[0] = 1; nfr[1] = 0;
    set_frame(0, 0, 64);
    build_expect(1518, 1'b0);
    do_reset();
    run_traffic(0, -1, ok);
    nchecks++;
    if (ok !== 1'b1) begin nerrors++; $display("FAIL single_handshake: ok got %0d need 1", ok); end
    nchecks++;
    if (first_beat_cyc - valid_rise_cyc !== 1) begin
      nerrors++;
      $display("FAIL single_latency: got %0d cycles need 1", first_beat_cyc - valid_rise_cyc);
    end
    nchecks++;
    if (obeat_q.size() !== 64) begin nerrors++; $display("FAIL single_beats: got %0d need 64", obeat_q.size()); end
    mm = stream_mismatch();
    nchecks++;
    if (mm !== -1) begin nerrors++; $display("FAIL single_stream: first bad beat got %0d need -1", mm); end
    nchecks++;
    if (ostat_q.size() !== 1 || ostat_q[0] !== exp_stat[0]) begin
      nerrors++;
      $display("FAIL single_stat: got n=%0d %h need n=1 %h", ostat_q.size(),
               (ostat_q.size() > 0) ? ostat_q[0] : 13'h0, exp_stat[0]);
    end
  endtask

  task automatic test_arbitration(input bit strict);
    bit ok;
    int mm;
    sel = strict ? 2'd1 : 2'd0; rdy_rand = 1'b0;
    nfr[0] = 2; nfr[1] = 2;
    for (int f = 0; f < 2; f++) begin
      set_frame(0, f, 100);
      set_frame(1, f, 100);
    end
    build_expect(1518, strict);
    do_reset();
    run_traffic(0, -1, ok);
    nchecks++;
    if (ok !== 1'b1) begin nerrors++; $display("FAIL arb%0d_handshake: ok got %0d need 1", strict, ok); end
    mm = stream_mismatch();
    nchecks++;
    if (mm !== -1) begin nerrors++; $display("FAIL arb%0d_stream: first bad beat got %0d need -1", strict, mm); end
    nchecks++;
    if (ostat_q.size() !== 4) begin nerrors++; $display("FAIL arb%0d_stat_count: got %0d need 4", strict, ostat_q.size()); end
    for (int i = 0; i < 4 && i < ostat_q.size(); i++) begin
      nchecks++;
      if (ostat_q[i] !== exp_stat[i]) begin
        nerrors++;
        $display("FAIL arb%0d_stat%0d: got port=%0d len=%0d need port=%0d len=%0d", strict, i,
                 ostat_q[i][12], ostat_q[i][10:0], exp_stat[i][12], exp_stat[i][10:0]);
      end
    end
    nchecks++;
    if (gap_viol !== 0) begin nerrors++; $display("FAIL arb%0d_idle_gap: violations got %0d need 0", strict, gap_viol); end
  endtask

  task automatic test_truncation();
    bit ok;
    int mm;
    sel = 2'd2; rdy_rand = 1'b0;
    nfr[0] = 0; nfr[1] = 1;
    set_frame(1, 0, 80);
    build_expect(64, 1'b0);
    do_reset();
    run_traffic(0, -1, ok);
    nchecks++;
    if (ok !== 1'b1) begin nerrors++; $display("FAIL trunc_drain: all 80 bytes accepted got %0d need 1", ok); end
    nchecks++;
    if (obeat_q.size() !== 64) begin nerrors++; $display("FAIL trunc_beats: got %0d need 64", obeat_q.size()); end
    mm = stream_mismatch();
    nchecks++;
    if (mm !== -1) begin nerrors++; $display("FAIL trunc_stream: first bad beat got %0d need -1", mm); end
    nchecks++;
    if (ostat_q.size() !== 1 || ostat_q[0] !== {1'b1, 1'b1, 11'd64}) begin
      nerrors++;
      $display("FAIL trunc_stat: got n=%0d %h need n=1 %h", ostat_q.size(),
               (ostat_q.size() > 0) ? ostat_q[0] : 13'h0, {1'b1, 1'b1, 11'd64});
    end
    nchecks++;
    if (busy !== 1'b0) begin nerrors++; $display("FAIL trunc_busy_end: got %0d need 0", busy); end
  endtask

  task automatic test_boundary();
    bit ok;
    int mm;
    sel = 2'd0; rdy_rand = 1'b1;
    nfr[0] = 3; nfr[1] = 0;
    set_frame(0, 0, $urandom_range(1000, 1517));
    set_frame(0, 1, 1518);
    set_frame(0, 2, 1519);
    build_expect(1518, 1'b0);
    do_reset();
    run_traffic(30, -1, ok);
    rdy_rand = 1'b0;
    nchecks++;
    if (ok !== 1'b1) begin nerrors++; $display("FAIL bound_handshake: ok got %0d need 1", ok); end
    mm = stream_mismatch();
    nchecks++;
    if (mm !== -1) begin nerrors++; $display("FAIL bound_stream: first bad beat got %0d need -1", mm); end
    nchecks++;
    if (ostat_q.size() !== 3) begin nerrors++; $display("FAIL bound_stat_count: got %0d need 3", ostat_q.size()); end
    for (int i = 0; i < 3 && i < ostat_q.size(); i++) begin
      nchecks++;
      if (ostat_q[i] !== exp_stat[i]) begin
        nerrors++;
        $display("FAIL bound_stat%0d: got trunc=%0d len=%0d need trunc=%0d len=%0d", i,
                 ostat_q[i][11], ostat_q[i][10:0], exp_stat[i][11], exp_stat[i][10:0]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int mm;
    sel = 2'd0; rdy_rand = 1'b0;
    nfr[0] = 1; nfr[1] = 0;
    set_frame(0, 0, 200);
    do_reset();
    run_traffic(0, 30, ok);
    tx_rst = 1'b1;
    #1;
    nchecks++;
    if ({m_tvalid, s0_tready, s1_tready, busy, stat_valid} !== 5'b0) begin
      nerrors++;
      $display("FAIL midrst_outputs: got %b need 00000", {m_tvalid, s0_tready, s1_tready, busy, stat_valid});
    end
    do_reset();
    repeat (4) @(posedge tx_clk);
    #1;
    nchecks++;
    if (obeat_q.size() !== 30 || ostat_q.size() !== 0) begin
      nerrors++;
      $display("FAIL midrst_abandon: beats=%0d stats=%0d need beats=30 stats=0", obeat_q.size(), ostat_q.size());
    end
    set_frame(0, 0, $urandom_range(64, 300));
    build_expect(1518, 1'b0);
    run_traffic(0, -1, ok);
    nchecks++;
    if (ok !== 1'b1) begin nerrors++; $display("FAIL midrst_handshake: ok got %0d need 1", ok); end
    mm = stream_mismatch();
    nchecks++;
    if (mm !== -1) begin nerrors++; $display("FAIL midrst_stream: first bad beat got %0d need -1", mm); end
    nchecks++;
    if (ostat_q.size() !== 1 || ostat_q[0] !== exp_stat[0]) begin
      nerrors++;
      $display("FAIL midrst_stat: got n=%0d %h need n=1 %h", ostat_q.size(),
               (ostat_q.size() > 0) ? ostat_q[0] : 13'h0, exp_stat[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_arbitration(1'b0);
    test_arbitration(1'b1);
    test_truncation();
    test_boundary();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

`default_nettype wire
